// File: rtl/dcm_prog_pkg.sv
// ============================================================================
// Module : dcm_prog_pkg
// Brief  : Shared states, frame constants and field conversion for dcm_prog_rx.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dcm_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_END   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_GOCHK = 3'd5,
        ST_APPLY = 3'd6
    } state_t;

    localparam int   LOAD_BITS = 10;
    localparam int   DATA_BITS = 8;
    localparam logic SEL_D     = 1'b0;
    localparam logic SEL_M     = 1'b1;

    // Frames carry value-1 so that 256 fits in the 8-bit field.
    function automatic logic [8:0] field_to_val(input logic [DATA_BITS-1:0] field);
        return {1'b0, field} + 9'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcm_prog_shift.sv
// ============================================================================
// Module : dcm_prog_shift
// Brief  : 8-bit LSB-first shift register with bit counter and done flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dcm_prog_shift
    import dcm_prog_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 bit_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 last_o,
    output logic                 done_o
);

    localparam int CW = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0] data_q;
    logic [CW-1:0]        cnt_q;
    logic                 done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (en_i) begin
            // First bit received ends up in bit 0 after all shifts.
            data_q <= {bit_i, data_q[DATA_BITS-1:1]};
            cnt_q  <= cnt_q + CW'(1);
            if (last_o) begin
                done_q <= 1'b1;
            end
        end
    end

    assign last_o = (cnt_q == CW'(DATA_BITS - 1));
    assign data_o = data_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/dcm_prog_rx.sv
// ============================================================================
// Module : dcm_prog_rx
// Brief  : DCM_CLKGEN serial programming responder (load-D/load-M/GO frames).
//          Optional build macro: DCMPROG_RANGE_CHECK_EN rejects M=1 loads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dcm_prog_rx
    import dcm_prog_pkg::*;
#(
    parameter int DEFAULT_M    = 31,
    parameter int DEFAULT_D    = 21,
    parameter int APPLY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       progen,
    input  logic       progdata,
    output logic       progdone,
    output logic [8:0] mult,
    output logic [8:0] div,
    output logic       locked,
    output logic       apply,
    output logic       frame_err
);

    state_t         state_q;
    logic           sel_q;
    logic [8:0]     staged_m_q;
    logic [8:0]     staged_d_q;
    logic [8:0]     mult_q;
    logic [8:0]     div_q;
    logic [7:0]     cnt_q;
    logic           progdone_q;
    logic           locked_q;
    logic           apply_q;
    logic           frame_err_q;
    logic           busy_err_q;

    logic [DATA_BITS-1:0] w_field;
    logic                 w_shift_last;
    logic                 w_shift_done;
    logic                 w_shift_clr;
    logic                 w_shift_en;

    assign w_shift_clr = (state_q == ST_SEL);
    assign w_shift_en  = (state_q == ST_SHIFT) && progen;

    dcm_prog_shift u_shift (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_shift_clr),
        .en_i   (w_shift_en),
        .bit_i  (progdata),
        .data_o (w_field),
        .last_o (w_shift_last),
        .done_o (w_shift_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_D;
            staged_m_q  <= 9'(DEFAULT_M);
            staged_d_q  <= 9'(DEFAULT_D);
            mult_q      <= 9'(DEFAULT_M);
            div_q       <= 9'(DEFAULT_D);
            cnt_q       <= '0;
            progdone_q  <= 1'b1;
            locked_q    <= 1'b1;
            apply_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_err_q  <= 1'b0;
        end else begin
            apply_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (progen) begin
                        state_q <= progdata ? ST_SEL : ST_GOCHK;
                    end
                end
                ST_SEL: begin
                    if (progen) begin
                        sel_q   <= progdata;
                        state_q <= ST_SHIFT;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (!progen) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (w_shift_last) begin
                        state_q <= ST_END;
                    end
                end
                ST_END: begin
                    if (progen) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_DRAIN;
                    end else begin
                        state_q <= ST_IDLE;
                        if (!w_shift_done) begin
                            frame_err_q <= 1'b1;
                        end else if (sel_q == SEL_D) begin
                            staged_d_q <= field_to_val(w_field);
                        end else begin
`ifdef DCMPROG_RANGE_CHECK_EN
                            if (w_field == '0) begin
                                frame_err_q <= 1'b1;
                            end else begin
                                staged_m_q <= field_to_val(w_field);
                            end
`else
                            staged_m_q <= field_to_val(w_field);
`endif
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!progen) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GOCHK: begin
                    if (progen) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_DRAIN;
                    end else begin
                        progdone_q <= 1'b0;
                        locked_q   <= 1'b0;
                        busy_err_q <= 1'b0;
                        cnt_q      <= 8'(APPLY_CYCLES);
                        state_q    <= ST_APPLY;
                        // With a one-cycle apply window the commit lands here.
                        if (APPLY_CYCLES == 1) begin
                            mult_q  <= staged_m_q;
                            div_q   <= staged_d_q;
                            apply_q <= 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    if (progen && !busy_err_q) begin
                        frame_err_q <= 1'b1;
                        busy_err_q  <= 1'b1;
                    end
                    if (cnt_q == 8'd1) begin
                        progdone_q <= 1'b1;
                        locked_q   <= 1'b1;
                        state_q    <= (busy_err_q || progen) ? ST_DRAIN : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd2) begin
                            mult_q  <= staged_m_q;
                            div_q   <= staged_d_q;
                            apply_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign progdone  = progdone_q;
    assign mult      = mult_q;
    assign div       = div_q;
    assign locked    = locked_q;
    assign apply     = apply_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dcm_prog_rx.sv
// ============================================================================
// Module : tb_dcm_prog_rx
// Brief  : Self-checking bench for dcm_prog_rx with a frame-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dcm_prog_rx;
    import dcm_prog_pkg::*;

    localparam int APPLY_CYC = 16;
    localparam int DEF_M     = 31;
    localparam int DEF_D     = 21;
    localparam int TIMEOUT   = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       progen;
    logic       progdata;
    logic       progdone;
    logic [8:0] mult;
    logic [8:0] div;
    logic       locked;
    logic       apply;
    logic       frame_err;

    dcm_prog_rx #(
        .DEFAULT_M    (DEF_M),
        .DEFAULT_D    (DEF_D),
        .APPLY_CYCLES (APPLY_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .progen    (progen),
        .progdata  (progdata),
        .progdone  (progdone),
        .mult      (mult),
        .div       (div),
        .locked    (locked),
        .apply     (apply),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int err_cnt      = 0;
    int app_cnt      = 0;

    // Reference model: staged and committed values as plain integers.
    int m_staged, d_staged, m_cur, d_cur;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (apply === 1'b1)     app_cnt++;
    end

    function automatic bit rejects(input bit sel, input int field, input int len);
        bit bad;
        bad = (len != LOAD_BITS);
`ifdef DCMPROG_RANGE_CHECK_EN
        if (sel && field == 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    task automatic model_reset();
        m_staged = DEF_M; d_staged = DEF_D; m_cur = DEF_M; d_cur = DEF_D;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; progen = 1'b0; progdata = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Drives a load frame with progen high for len cycles; extra bits are 1.
    task automatic send_load(input bit sel, input int field, input int len);
        logic [9:0] frame;
        frame = {field[7:0], sel, 1'b1};
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            progen   = 1'b1;
            progdata = (i < LOAD_BITS) ? frame[i] : 1'b1;
        end
        @(negedge clk);
        progen   = 1'b0;
        progdata = 1'($urandom_range(0, 1));
        if (!rejects(sel, field, len)) begin
            if (sel) m_staged = field + 1;
            else     d_staged = field + 1;
        end
    endtask

    task automatic load_check(input string tag, input bit sel, input int field, input int len);
        int exp_err;
        err_cnt = 0;
        exp_err = rejects(sel, field, len) ? 1 : 0;
        send_load(sel, field, len);
        settle();
        tests_run++;
        if (err_cnt !== exp_err) begin
            tests_failed++;
            $display("FAIL %s frame_err pulses: got %0d expected %0d", tag, err_cnt, exp_err);
        end
    endtask

    // GO frame plus full apply observation; busy_at>0 injects progen mid-apply.
    task automatic do_go(input string tag, input int busy_at);
        int low;
        int exp_err;
        err_cnt = 0;
        app_cnt = 0;
        exp_err = (busy_at > 0) ? 1 : 0;
        @(negedge clk);
        progen = 1'b1; progdata = 1'b0;
        @(negedge clk);
        progen = 1'b0; progdata = 1'($urandom_range(0, 1));
        @(negedge clk);
        tests_run++;
        if (progdone !== 1'b0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s go_ack: progdone=%0b locked=%0b expected 0/0", tag, progdone, locked);
        end
        low = 0;
        while (progdone !== 1'b1 && low < TIMEOUT) begin
            low++;
            if (busy_at > 0 && low == busy_at) begin
                progen = 1'b1; progdata = 1'($urandom_range(0, 1));
            end
            if (busy_at > 0 && low == busy_at + 3) progen = 1'b0;
            @(negedge clk);
        end
        m_cur = m_staged;
        d_cur = d_staged;
        tests_run++;
        if (low !== APPLY_CYC) begin
            tests_failed++;
            $display("FAIL %s progdone_low_cycles: got %0d expected %0d", tag, low, APPLY_CYC);
        end
        settle();
        tests_run++;
        if (app_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s apply_pulses: got %0d expected 1", tag, app_cnt);
        end
        tests_run++;
        if (mult !== 9'(m_cur) || div !== 9'(d_cur)) begin
            tests_failed++;
            $display("FAIL %s mult/div: got %0d/%0d expected %0d/%0d", tag, mult, div, m_cur, d_cur);
        end
        tests_run++;
        if (locked !== 1'b1 || progdone !== 1'b1 || err_cnt !== exp_err) begin
            tests_failed++;
            $display("FAIL %s end_state: locked=%0b progdone=%0b errs=%0d expected 1/1/%0d",
                     tag, locked, progdone, err_cnt, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; progen = 1'b0; progdata = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (mult !== 9'(DEF_M) || div !== 9'(DEF_D) || progdone !== 1'b1 ||
            locked !== 1'b1 || apply !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: mult=%0d div=%0d pd=%0b lk=%0b ap=%0b fe=%0b expected 31 21 1 1 0 0",
                     mult, div, progdone, locked, apply, frame_err);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        load_check("basic_d", 1'b0, 8'h09, LOAD_BITS);
        load_check("basic_m", 1'b1, 8'h1D, LOAD_BITS);
        do_go("basic_go", 0);
        tests_run++;
        if (mult !== 9'd30 || div !== 9'd10) begin
            tests_failed++;
            $display("FAIL basic_values: got %0d/%0d expected 30/10", mult, div);
        end
    endtask

    task automatic test_max_m();
        do_reset();
        load_check("max_m", 1'b1, 8'hFF, LOAD_BITS);
        do_go("max_go", 0);
        tests_run++;
        if (mult !== 9'd256 || div !== 9'd21) begin
            tests_failed++;
            $display("FAIL max_values: got %0d/%0d expected 256/21", mult, div);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        load_check("short_d", 1'b0, int'($urandom_range(0, 255)), 6);
        do_go("short_go", 0);
    endtask

    task automatic test_long_frame();
        do_reset();
        load_check("long_m", 1'b1, 8'h40, 12);
        do_go("long_go", 0);
    endtask

    task automatic test_go_only();
        do_reset();
        do_go("go_only", 0);
    endtask

    task automatic test_m_zero();
        do_reset();
        load_check("m_zero", 1'b1, 0, LOAD_BITS);
        do_go("m_zero_go", 0);
    endtask

    task automatic test_busy();
        load_check("busy_pre", 1'b0, 8'h2A, LOAD_BITS);
        do_go("busy_go", 4);
    endtask

    task automatic test_async_reset();
        load_check("ar_m", 1'b1, 8'h05, LOAD_BITS);
        // Start a GO, then hit reset between clock edges mid-apply.
        @(negedge clk);
        progen = 1'b1; progdata = 1'b0;
        @(negedge clk);
        progen = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (progdone !== 1'b1 || locked !== 1'b1 || mult !== 9'(DEF_M) || div !== 9'(DEF_D)) begin
            tests_failed++;
            $display("FAIL async_reset: pd=%0b lk=%0b mult=%0d div=%0d expected 1 1 31 21",
                     progdone, locked, mult, div);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_go("post_reset_go", 0);
    endtask

    task automatic test_back_to_back();
        int nloads, sel, field, len;
        for (int it = 0; it < 12; it++) begin
            nloads = int'($urandom_range(1, 4));
            for (int k = 0; k < nloads; k++) begin
                sel   = int'($urandom_range(0, 1));
                field = int'($urandom_range(0, 255));
                case ($urandom_range(0, 5))
                    0:       len = int'($urandom_range(1, 9));
                    1:       len = int'($urandom_range(11, 13));
                    default: len = LOAD_BITS;
                endcase
                load_check("rand_load", sel[0], field, len);
            end
            do_go("rand_go", 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_m();
        test_short_frame();
        test_long_frame();
        test_go_only();
        test_m_zero();
        test_busy();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
